// File: rtl/acumulador_moedas.sv
// Coin-side front end of the vending machine: accumulates coins, requests a comparison,
// then dispenses or refunds unit by unit. Optional inactivity auto-refund under `TIMEOUT_EN.
module acumulador_moedas #(
  parameter int LARGURA        = 4,
  parameter int VALOR_MAX      = 15,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               moeda1,
  input  logic               moeda2,
  input  logic               confirmar,
  input  logic               cancelar,
  input  logic               liberarProduto,
  input  logic               devolverMoedas,
  output logic [LARGURA-1:0] valorMoedas,
  output logic               enable,
  output logic               entregaProduto,
  output logic               moedaDevolvida,
  output logic               moedaRejeitada,
  output logic               ocupado
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    ACUMULANDO = 3'd1,
    COMPARANDO = 3'd2,
    LIBERANDO  = 3'd3,
    DEVOLVENDO = 3'd4
  } estado_t;

  localparam logic [LARGURA+1:0] MAX_EXT = (LARGURA+2)'(VALOR_MAX);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] total_q, total_d;
  logic               entrega_q, entrega_d;
  logic               devolvida_q, devolvida_d;
  logic               rejeitada_q, rejeitada_d;

  logic [1:0]         incremento;
  logic [LARGURA+1:0] soma;
  logic [LARGURA-1:0] total_pos;
  logic               moeda_chegou;
  logic               pode_aceitar;
  logic               aceita_moeda;
  logic               expirou;

  // {moeda2, moeda1} read as an unsigned number is exactly moeda1 + 2*moeda2.
  assign incremento   = {moeda2, moeda1};
  assign soma         = {2'b00, total_q} + {{LARGURA{1'b0}}, incremento};
  assign moeda_chegou = moeda1 | moeda2;
  assign pode_aceitar = (estado_q == OCIOSO) || (estado_q == ACUMULANDO);
  assign aceita_moeda = pode_aceitar && moeda_chegou && (soma <= MAX_EXT);
  assign total_pos    = aceita_moeda ? soma[LARGURA-1:0] : total_q;

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

  logic [CW-1:0] ocioso_cnt_q, ocioso_cnt_d;

  assign expirou = (estado_q == ACUMULANDO) && !aceita_moeda &&
                   (ocioso_cnt_q == CW'(TIMEOUT_CICLOS - 1));

  always_comb begin
    ocioso_cnt_d = '0;
    if ((estado_d == ACUMULANDO) && (estado_q == ACUMULANDO) && !aceita_moeda)
      ocioso_cnt_d = ocioso_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ocioso_cnt_q <= '0;
    else       ocioso_cnt_q <= ocioso_cnt_d;
  end
`else
  assign expirou = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      total_q     <= '0;
      entrega_q   <= 1'b0;
      devolvida_q <= 1'b0;
      rejeitada_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      total_q     <= total_d;
      entrega_q   <= entrega_d;
      devolvida_q <= devolvida_d;
      rejeitada_q <= rejeitada_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    total_d  = total_q;
    case (estado_q)
      OCIOSO, ACUMULANDO: begin
        // An accepted coin in the same cycle is counted before confirm/cancel.
        total_d = total_pos;
        if (cancelar && (total_q != '0))
          estado_d = DEVOLVENDO;
        else if (confirmar && (total_pos != '0))
          estado_d = COMPARANDO;
        else if (expirou)
          estado_d = DEVOLVENDO;
        else if (total_pos != '0)
          estado_d = ACUMULANDO;
        else
          estado_d = OCIOSO;
      end
      COMPARANDO: begin
        if (liberarProduto)
          estado_d = LIBERANDO;
        else if (devolverMoedas)
          estado_d = DEVOLVENDO;
      end
      LIBERANDO: begin
        total_d  = '0;
        estado_d = OCIOSO;
      end
      DEVOLVENDO: begin
        if (total_q <= LARGURA'(1)) begin
          total_d  = '0;
          estado_d = OCIOSO;
        end else begin
          total_d = total_q - LARGURA'(1);
        end
      end
      default: begin
        total_d  = '0;
        estado_d = OCIOSO;
      end
    endcase
  end

  // Pulse registers mirror the state being entered, so each lasts exactly one state-cycle.
  always_comb begin
    entrega_d   = (estado_d == LIBERANDO);
    devolvida_d = (estado_d == DEVOLVENDO);
    rejeitada_d = moeda_chegou && !aceita_moeda;
  end

  assign valorMoedas    = total_q;
  assign entregaProduto = entrega_q;
  assign moedaDevolvida = devolvida_q;
  assign moedaRejeitada = rejeitada_q;
  assign enable         = (estado_q == COMPARANDO);
  assign ocupado        = (estado_q == COMPARANDO) || (estado_q == LIBERANDO) ||
                          (estado_q == DEVOLVENDO);

endmodule

// File: tb/tb_acumulador_moedas.sv
// Self-checking bench for acumulador_moedas: directed scenarios plus randomized traffic
// against a transaction-level model of the coin front end.
module tb_acumulador_moedas;
  localparam int LARG = 4;
  localparam int VMAX = 15;
  localparam int TOC  = 8;
`ifdef TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, moeda1, moeda2, confirmar, cancelar, liberarProduto, devolverMoedas;
  logic [LARG-1:0] valorMoedas;
  logic enable, entregaProduto, moedaDevolvida, moedaRejeitada, ocupado;

  int testes = 0;
  int falhas = 0;

  // Model: money held, plus which phase of a purchase is in progress.
  int m_total, m_idle;
  bit m_comparando, m_entregando, m_devolvendo, m_rejeita;

  acumulador_moedas #(.LARGURA(LARG), .VALOR_MAX(VMAX), .TIMEOUT_CICLOS(TOC)) dut (
    .clk(clk), .reset(reset), .moeda1(moeda1), .moeda2(moeda2),
    .confirmar(confirmar), .cancelar(cancelar),
    .liberarProduto(liberarProduto), .devolverMoedas(devolverMoedas),
    .valorMoedas(valorMoedas), .enable(enable), .entregaProduto(entregaProduto),
    .moedaDevolvida(moedaDevolvida), .moedaRejeitada(moedaRejeitada), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input int esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic modelo(input bit r, input bit m1, input bit m2, input bit conf,
                        input bit canc, input bit lib, input bit dev);
    int c, novo;
    bit aceita, sai;
    if (r) begin
      m_total = 0; m_idle = 0;
      m_comparando = 0; m_entregando = 0; m_devolvendo = 0; m_rejeita = 0;
      return;
    end
    c = int'(m1) + 2 * int'(m2);
    if (m_entregando) begin
      m_entregando = 0; m_total = 0; m_rejeita = (c > 0);
    end else if (m_devolvendo) begin
      m_total--;
      if (m_total == 0) m_devolvendo = 0;
      m_rejeita = (c > 0);
    end else if (m_comparando) begin
      if (lib) begin m_comparando = 0; m_entregando = 1; end
      else if (dev) begin m_comparando = 0; m_devolvendo = 1; end
      m_rejeita = (c > 0);
    end else begin
      aceita    = (c > 0) && (m_total + c <= VMAX);
      m_rejeita = (c > 0) && !aceita;
      novo      = aceita ? m_total + c : m_total;
      sai       = 1;
      if (canc && m_total > 0) m_devolvendo = 1;
      else if (conf && novo > 0) m_comparando = 1;
      else if (TO_EN && m_total > 0 && !aceita && m_idle + 1 >= TOC) m_devolvendo = 1;
      else sai = 0;
      if (sai || aceita || m_total == 0) m_idle = 0;
      else m_idle++;
      m_total = novo;
    end
  endtask

  task automatic ciclo(input bit r, input bit m1, input bit m2, input bit conf,
                       input bit canc, input bit lib, input bit dev);
    reset = r; moeda1 = m1; moeda2 = m2; confirmar = conf; cancelar = canc;
    liberarProduto = lib; devolverMoedas = dev;
    @(posedge clk);
    modelo(r, m1, m2, conf, canc, lib, dev);
    #1;
    verifica("valorMoedas", valorMoedas, m_total);
    verifica("enable", enable, int'(m_comparando));
    verifica("entregaProduto", entregaProduto, int'(m_entregando));
    verifica("moedaDevolvida", moedaDevolvida, int'(m_devolvendo));
    verifica("moedaRejeitada", moedaRejeitada, int'(m_rejeita));
    verifica("ocupado", ocupado, int'(m_comparando | m_entregando | m_devolvendo));
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) ciclo(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int pulsos;
    bit r, m1, m2, cf, cc, lb, dv;

    ciclo(1, 1, 1, 1, 1, 1, 1);
    ciclo(1, 0, 0, 0, 0, 0, 0);
    verifica("reset_valor", valorMoedas, 0);
    verifica("reset_ocupado", ocupado, 0);

    // T1: 2+2, confirm, release
    ciclo(0, 0, 1, 0, 0, 0, 0);
    ciclo(0, 0, 1, 0, 0, 0, 0);
    ciclo(0, 0, 0, 1, 0, 0, 0);
    verifica("T1_enable", enable, 1);
    verifica("T1_valor", valorMoedas, 4);
    ciclo(0, 0, 0, 0, 0, 1, 0);
    verifica("T1_entrega", entregaProduto, 1);
    ciclo(0, 0, 0, 0, 0, 0, 0);
    verifica("T1_entrega_fim", entregaProduto, 0);
    verifica("T1_valor_fim", valorMoedas, 0);
    ocioso(1);

    // T2: 1+1+1, confirm, refund
    for (int i = 0; i < 3; i++) ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 0, 0, 1, 0, 0, 0);
    ciclo(0, 0, 0, 0, 0, 0, 1);
    pulsos = int'(moedaDevolvida);
    for (int i = 0; i < 5; i++) begin
      ciclo(0, 0, 0, 0, 0, 0, 0);
      pulsos += int'(moedaDevolvida);
    end
    verifica("T2_pulsos", pulsos, 3);
    verifica("T2_valor", valorMoedas, 0);

    // T3: saturation at VALOR_MAX
    for (int i = 0; i < 7; i++) ciclo(0, 0, 1, 0, 0, 0, 0);
    verifica("T3_valor14", valorMoedas, 14);
    ciclo(0, 0, 1, 0, 0, 0, 0);
    verifica("T3_rejeitada", moedaRejeitada, 1);
    verifica("T3_valor_mantido", valorMoedas, 14);
    ciclo(0, 1, 0, 0, 0, 0, 0);
    verifica("T3_valor15", valorMoedas, 15);
    ciclo(0, 0, 0, 0, 1, 0, 0);
    ocioso(16);
    verifica("T3_drenado", valorMoedas, 0);

    // T4: both coins with confirm in the same cycle
    ciclo(0, 1, 1, 1, 0, 0, 0);
    verifica("T4_valor", valorMoedas, 3);
    verifica("T4_enable", enable, 1);
    ciclo(0, 0, 0, 0, 0, 0, 1);
    ocioso(4);

    // T5: reset with 2 units still to refund
    for (int i = 0; i < 3; i++) ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 0, 0, 1, 0, 0, 0);
    ciclo(0, 0, 0, 0, 0, 0, 1);
    ciclo(0, 0, 0, 0, 0, 0, 0);
    verifica("T5_restam2", valorMoedas, 2);
    ciclo(1, 0, 0, 0, 0, 0, 0);
    verifica("T5_devolvida", moedaDevolvida, 0);
    verifica("T5_valor", valorMoedas, 0);
    ocioso(3);

    // T6: inactivity
    ciclo(0, 0, 1, 0, 0, 0, 0);
    pulsos = 0;
    for (int i = 0; i < 11; i++) begin
      ciclo(0, 0, 0, 0, 0, 0, 0);
      pulsos += int'(moedaDevolvida);
    end
    verifica("T6_pulsos", pulsos, TO_EN ? 2 : 0);
    verifica("T6_valor", valorMoedas, TO_EN ? 0 : 2);
    ciclo(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      m1 = ($urandom_range(0, 3) == 0);
      m2 = ($urandom_range(0, 3) == 0);
      cf = ($urandom_range(0, 7) == 0);
      cc = ($urandom_range(0, 15) == 0);
      lb = ($urandom_range(0, 2) == 0);
      dv = ($urandom_range(0, 2) == 0);
      if (cc) begin m1 = 0; m2 = 0; end
      ciclo(r, m1, m2, cf, cc, lb, dv);
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end
endmodule
